id_ex_stage: RTL

Decode-to-execute pipeline register of the 5-stage RISC-V core. It captures the operands read from the register file in decode. It applies a write-back bypass, because the register file writes on the clock edge and its same-cycle write is not visible to a combinational read. It also detects load-use hazards, inserting a bubble and stalling fetch/decode. Sits between the decode stage (register file read ports) and the ALU/execute stage.

---
 rtl/id_ex_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with write-back bypass
// and load-use hazard detection (bubble insertion, fetch/decode stall).
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   *_id              decode-stage instruction fields and register file data
//   RegWEn_wb,
//   rd_add_wb,
//   dataW_wb          write-back port, the same signals that write the regfile
//   flush_ex          redirect; kill the instruction entering EX
//   stall_ex_in       downstream hold; freeze the EX register
//   *_ex              registered execute-stage copies of the decode fields
//   stall_id          combinational; freeze the PC and the IF/ID register
//   bubble_count      saturating count of load-use bubbles inserted
module id_ex_stage #(
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              valid_id,
    input  logic [31:0]       pc_id,
    input  logic [4:0]        rs1_add_id,
    input  logic [4:0]        rs2_add_id,
    input  logic [4:0]        rd_add_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic [31:0]       rs1_data_id,
    input  logic [31:0]       rs2_data_id,
    input  logic [31:0]       imm_id,
    input  logic              regwen_id,
    input  logic              memread_id,
    input  logic [CTRL_W-1:0] ctrl_id,

    input  logic              RegWEn_wb,
    input  logic [4:0]        rd_add_wb,
    input  logic [31:0]       dataW_wb,

    input  logic              flush_ex,
    input  logic              stall_ex_in,

    output logic              valid_ex,
    output logic [31:0]       pc_ex,
    output logic [31:0]       imm_ex,
    output logic [31:0]       rs1_data_ex,
    output logic [31:0]       rs2_data_ex,
    output logic [4:0]        rs1_add_ex,
    output logic [4:0]        rs2_add_ex,
    output logic [4:0]        rd_add_ex,
    output logic              regwen_ex,
    output logic              memread_ex,
    output logic [CTRL_W-1:0] ctrl_ex,

    output logic              stall_id,
    output logic [15:0]       bubble_count
);

    // Everything that moves from decode into execute as one bundle.
    typedef struct packed {
        logic              valid;
        logic [31:0]       pc;
        logic [31:0]       imm;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [4:0]        rs1_add;
        logic [4:0]        rs2_add;
        logic [4:0]        rd_add;
        logic              regwen;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t         ex_q;
    ex_t         ex_load;
    logic [15:0] bubble_q;

    logic        wb_live;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    logic        load_in_ex;
    logic        rs1_dep;
    logic        rs2_dep;
    logic        hz;

    // The regfile only commits on the clock edge, so a write landing in
    // this cycle is invisible to the decode read. Substitute it here.
    // x0 is never bypassed: a write to it is architecturally discarded.
    always_comb begin
        wb_live = RegWEn_wb && (rd_add_wb != 5'd0);
        rs1_fwd = rs1_data_id;
        rs2_fwd = rs2_data_id;
        if (wb_live && (rd_add_wb == rs1_add_id)) begin
            rs1_fwd = dataW_wb;
        end
        if (wb_live && (rd_add_wb == rs2_add_id)) begin
            rs2_fwd = dataW_wb;
        end
    end

    // A load in EX whose result decode needs cannot be forwarded in time;
    // decode must wait one cycle while a bubble goes down the pipe.
    always_comb begin
        load_in_ex = ex_q.valid && ex_q.memread
                     && (ex_q.rd_add != 5'd0);
        rs1_dep    = rs1_used_id && (rs1_add_id == ex_q.rd_add);
        rs2_dep    = rs2_used_id && (rs2_add_id == ex_q.rd_add);
        hz         = load_in_ex && valid_id && (rs1_dep || rs2_dep)
                     && !flush_ex;
        stall_id   = (hz || stall_ex_in) && !flush_ex;
    end

    // Next contents on a normal load. An empty slot never writes rd
    // and never touches memory.
    always_comb begin
        ex_load          = '0;
        ex_load.valid    = valid_id;
        ex_load.pc       = pc_id;
        ex_load.imm      = imm_id;
        ex_load.rs1_data = rs1_fwd;
        ex_load.rs2_data = rs2_fwd;
        ex_load.rs1_add  = rs1_add_id;
        ex_load.rs2_add  = rs2_add_id;
        ex_load.rd_add   = rd_add_id;
        ex_load.regwen   = regwen_id && valid_id;
        ex_load.memread  = memread_id && valid_id;
        ex_load.ctrl     = ctrl_id;
    end

    // Priority: reset, flush, downstream hold, bubble, load.
    // A hold beats the bubble, so a held load keeps decode stalled
    // without counting a bubble for every held cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            bubble_q <= '0;
        end else if (flush_ex) begin
            ex_q     <= '0;
        end else if (!stall_ex_in) begin
            if (hz) begin
                ex_q.valid   <= 1'b0;
                ex_q.regwen  <= 1'b0;
                ex_q.memread <= 1'b0;
                if (bubble_q != 16'hFFFF) begin
                    bubble_q <= bubble_q + 16'd1;
                end
            end else begin
                ex_q <= ex_load;
            end
        end
    end

    assign valid_ex     = ex_q.valid;
    assign pc_ex        = ex_q.pc;
    assign imm_ex       = ex_q.imm;
    assign rs1_data_ex  = ex_q.rs1_data;
    assign rs2_data_ex  = ex_q.rs2_data;
    assign rs1_add_ex   = ex_q.rs1_add;
    assign rs2_add_ex   = ex_q.rs2_add;
    assign rd_add_ex    = ex_q.rd_add;
    assign regwen_ex    = ex_q.regwen;
    assign memread_ex   = ex_q.memread;
    assign ctrl_ex      = ex_q.ctrl;
    assign bubble_count = bubble_q;

endmodule
